// File: rtl/gan_pkg.sv
// Shared definitions for the GAN layer sequencer: default widths and the
// sequencer state encoding.
package gan_pkg;

    localparam int unsigned IDX_W_DEF   = 5;
    localparam int unsigned WADDR_W_DEF = 10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_MAC   = 3'd2,
        S_BIAS  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/gan_layer_sequencer_if.sv
// Control/datapath bundle of the layer sequencer. The master side drives the
// run request and MAC handshake; the slave side is the sequencer itself.
interface gan_layer_sequencer_if
    import gan_pkg::*;
#(
    parameter int unsigned IDX_W   = IDX_W_DEF,
    parameter int unsigned WADDR_W = WADDR_W_DEF
);
    logic               Start;
    logic               Abort;
    logic [IDX_W-1:0]   Cfg_n_in;
    logic [IDX_W-1:0]   Cfg_n_out;
    logic               Mac_ready;
    logic [WADDR_W-1:0] W_addr;
    logic [IDX_W-1:0]   In_addr;
    logic [IDX_W-1:0]   B_addr;
    logic [IDX_W-1:0]   Out_addr;
    logic               Clr_acc;
    logic               En_mac;
    logic               En_bias;
    logic               Wr_out;
    logic               Busy;
    logic               Done;
    logic               Err;

    modport master (
        output Start, Abort, Cfg_n_in, Cfg_n_out, Mac_ready,
        input  W_addr, In_addr, B_addr, Out_addr,
        input  Clr_acc, En_mac, En_bias, Wr_out, Busy, Done, Err
    );

    modport slave (
        input  Start, Abort, Cfg_n_in, Cfg_n_out, Mac_ready,
        output W_addr, In_addr, B_addr, Out_addr,
        output Clr_acc, En_mac, En_bias, Wr_out, Busy, Done, Err
    );

endinterface

// File: rtl/gan_counter.sv
// Up-counter with synchronous clear (priority) and count enable.
module gan_counter #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/gan_layer_sequencer.sv
// Sequences CLR/MAC/BIAS/WRITE steps for a fully-connected layer, producing
// weight, input, bias and output addresses plus the datapath strobes.
module gan_layer_sequencer
    import gan_pkg::*;
#(
    parameter int unsigned IDX_W   = IDX_W_DEF,
    parameter int unsigned WADDR_W = WADDR_W_DEF
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Abort,
    input  logic [IDX_W-1:0]   Cfg_n_in,
    input  logic [IDX_W-1:0]   Cfg_n_out,
    input  logic               Mac_ready,
    output logic [WADDR_W-1:0] W_addr,
    output logic [IDX_W-1:0]   In_addr,
    output logic [IDX_W-1:0]   B_addr,
    output logic [IDX_W-1:0]   Out_addr,
    output logic               Clr_acc,
    output logic               En_mac,
    output logic               En_bias,
    output logic               Wr_out,
    output logic               Busy,
    output logic               Done,
    output logic               Err
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] n_in_q, n_in_d;
    logic [IDX_W-1:0] n_out_q, n_out_d;
    logic             err_q, err_d;

    logic               n_clr, n_en, i_clr, i_en, w_clr, w_en, mac_fire;
    logic [IDX_W-1:0]   n_cnt, i_cnt;
    logic [WADDR_W-1:0] w_cnt;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            n_in_q  <= '0;
            n_out_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_in_q  <= n_in_d;
            n_out_q <= n_out_d;
            err_q   <= err_d;
        end
    end

    // W_addr advances in lock-step with i and is never cleared between
    // neurons, so it tracks n*n_in+i without a multiplier.
    always_comb begin
        state_d  = state_q;
        n_in_d   = n_in_q;
        n_out_d  = n_out_q;
        err_d    = 1'b0;
        n_clr    = 1'b0;
        n_en     = 1'b0;
        i_clr    = 1'b0;
        i_en     = 1'b0;
        w_clr    = 1'b0;
        w_en     = 1'b0;
        mac_fire = 1'b0;
        if (state_q != S_IDLE && Abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        if (Cfg_n_in == '0 || Cfg_n_out == '0) begin
                            err_d = 1'b1;
                        end else begin
                            n_in_d  = Cfg_n_in;
                            n_out_d = Cfg_n_out;
                            n_clr   = 1'b1;
                            i_clr   = 1'b1;
                            w_clr   = 1'b1;
                            state_d = S_CLR;
                        end
                    end
                end
                S_CLR: begin
                    i_clr   = 1'b1;
                    state_d = S_MAC;
                end
                S_MAC: begin
                    if (Mac_ready) begin
                        mac_fire = 1'b1;
                        i_en     = 1'b1;
                        w_en     = 1'b1;
                        if (i_cnt == n_in_q - IDX_W'(1)) begin
                            state_d = S_BIAS;
                        end
                    end
                end
                S_BIAS: state_d = S_WRITE;
                S_WRITE: begin
                    if (n_cnt == n_out_q - IDX_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        n_en    = 1'b1;
                        state_d = S_CLR;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    gan_counter #(.W(IDX_W)) u_n_cnt (
        .clk(Clock), .rst_n(Reset), .clr_i(n_clr), .en_i(n_en), .q_o(n_cnt)
    );

    gan_counter #(.W(IDX_W)) u_i_cnt (
        .clk(Clock), .rst_n(Reset), .clr_i(i_clr), .en_i(i_en), .q_o(i_cnt)
    );

    gan_counter #(.W(WADDR_W)) u_w_cnt (
        .clk(Clock), .rst_n(Reset), .clr_i(w_clr), .en_i(w_en), .q_o(w_cnt)
    );

    assign W_addr   = w_cnt;
    assign In_addr  = i_cnt;
    assign B_addr   = n_cnt;
    assign Out_addr = n_cnt;
    assign Clr_acc  = (state_q == S_CLR);
    assign En_mac   = mac_fire;
    assign En_bias  = (state_q == S_BIAS);
    assign Wr_out   = (state_q == S_WRITE);
    assign Busy     = (state_q != S_IDLE);
    assign Done     = (state_q == S_DONE);
    assign Err      = err_q;

endmodule

// File: tb/tb_gan_layer_sequencer.sv
// Scoreboard bench for gan_layer_sequencer: each run pushes its expected strobe
// events; a forked monitor pops and compares every strobe the DUT raises.
module tb_gan_layer_sequencer;

    localparam int unsigned IW = 5;
    localparam int unsigned AW = 10;

    localparam logic [5:0] K_CLR  = 6'b100000;
    localparam logic [5:0] K_MAC  = 6'b010000;
    localparam logic [5:0] K_BIAS = 6'b001000;
    localparam logic [5:0] K_WR   = 6'b000100;
    localparam logic [5:0] K_DONE = 6'b000010;
    localparam logic [5:0] K_ERR  = 6'b000001;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    gan_layer_sequencer_if #(.IDX_W(IW), .WADDR_W(AW)) bus ();

    gan_layer_sequencer #(.IDX_W(IW), .WADDR_W(AW)) dut (
        .Clock    (clk),
        .Reset    (rst_n),
        .Start    (bus.Start),
        .Abort    (bus.Abort),
        .Cfg_n_in (bus.Cfg_n_in),
        .Cfg_n_out(bus.Cfg_n_out),
        .Mac_ready(bus.Mac_ready),
        .W_addr   (bus.W_addr),
        .In_addr  (bus.In_addr),
        .B_addr   (bus.B_addr),
        .Out_addr (bus.Out_addr),
        .Clr_acc  (bus.Clr_acc),
        .En_mac   (bus.En_mac),
        .En_bias  (bus.En_bias),
        .Wr_out   (bus.Wr_out),
        .Busy     (bus.Busy),
        .Done     (bus.Done),
        .Err      (bus.Err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [5:0] strb;
        int         addr;
        int         ia;
    } ev_t;

    ev_t sb[$];
    int  total = 0;
    int  bad = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    int  last_w = -1;

    function automatic void check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (cyc=%0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push(int c, logic [5:0] s, int a, int ia);
        ev_t e;
        e.cyc  = c;
        e.strb = s;
        e.addr = a;
        e.ia   = ia;
        sb.push_back(e);
    endfunction

    // Expected timeline, relative to the cycle Start is presented (cycle 0).
    function automatic void gen_run(int base, int nin, int nout, int slo, int shi, int cut);
        int t;
        if (nin == 0 || nout == 0) begin
            push(base + 1, K_ERR, -1, -1);
            return;
        end
        t = 1;
        for (int n = 0; n < nout; n++) begin
            if (t < cut) push(base + t, K_CLR, -1, -1);
            t++;
            for (int i = 0; i < nin; i++) begin
                while (t >= slo && t <= shi) t++;
                if (t < cut) push(base + t, K_MAC, n * nin + i, i);
                t++;
            end
            if (t < cut) push(base + t, K_BIAS, n, -1);
            t++;
            if (t < cut) push(base + t, K_WR, n, -1);
            t++;
        end
        if (t < cut) push(base + t, K_DONE, -1, -1);
    endfunction

    task automatic monitor();
        ev_t        e;
        logic [5:0] s;
        int         a;
        forever begin
            @(negedge clk);
            s = {bus.Clr_acc, bus.En_mac, bus.En_bias, bus.Wr_out, bus.Done, bus.Err};
            if (bus.Wr_out) wr_cnt++;
            if (bus.Done) done_cnt++;
            if (bus.En_mac) last_w = int'(bus.W_addr);
            if (s != '0) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_strobe cyc=%0d got=%b want=none", cyc, s);
                end else begin
                    e = sb.pop_front();
                    a = bus.En_mac  ? int'(bus.W_addr) :
                        bus.En_bias ? int'(bus.B_addr) :
                        bus.Wr_out  ? int'(bus.Out_addr) : -1;
                    if (cyc != e.cyc || s != e.strb || (e.addr >= 0 && a != e.addr) ||
                        (e.ia >= 0 && int'(bus.In_addr) != e.ia)) begin
                        bad++;
                        $display("FAIL event got cyc=%0d strb=%b addr=%0d in=%0d want cyc=%0d strb=%b addr=%0d in=%0d",
                                 cyc, s, a, bus.In_addr, e.cyc, e.strb, e.addr, e.ia);
                    end
                end
            end
        end
    endtask

    // Drives one run; Cfg_* is scrambled and Start re-pulsed mid-run to show
    // both are ignored while busy.
    task automatic run(int nin, int nout, int slo, int shi, int abt, int cut,
                       int min_rel, int idle_at, int hold_w);
        int base;
        int rel;
        bit drained;
        @(posedge clk);
        #1;
        base          = cyc;
        bus.Cfg_n_in  = IW'(nin);
        bus.Cfg_n_out = IW'(nout);
        bus.Start     = 1'b1;
        bus.Abort     = 1'b0;
        bus.Mac_ready = 1'b1;
        gen_run(base, nin, nout, slo, shi, cut);
        drained = 1'b0;
        for (int k = 0; k < 2500; k++) begin
            @(negedge clk);
            #1;
            rel = cyc - base;
            if (idle_at >= 0 && rel >= idle_at && rel <= idle_at + 1)
                check("busy_low", int'(bus.Busy), 0);
            if (hold_w >= 0 && rel >= slo && rel <= shi) begin
                check("stall_w_addr", int'(bus.W_addr), hold_w);
                check("stall_en_mac", int'(bus.En_mac), 0);
            end
            if (sb.size() == 0 && rel >= min_rel) begin
                drained = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            rel           = cyc - base;
            bus.Start     = (rel == 5);
            bus.Cfg_n_in  = IW'(7);
            bus.Cfg_n_out = IW'(1);
            bus.Mac_ready = !(rel >= slo && rel <= shi);
            bus.Abort     = (rel == abt);
        end
        total++;
        if (!drained) begin
            bad++;
            $display("FAIL timeout pending=%0d want=0", sb.size());
            sb.delete();
        end
        bus.Start = 1'b0;
        bus.Abort = 1'b0;
        bus.Mac_ready = 1'b1;
    endtask

    task automatic check_quiet(string name);
        check({name, "_strobes"}, int'({bus.Clr_acc, bus.En_mac, bus.En_bias, bus.Wr_out,
                                         bus.Done, bus.Err, bus.Busy}), 0);
        check({name, "_w_addr"}, int'(bus.W_addr), 0);
        check({name, "_idx"}, int'({bus.In_addr, bus.B_addr, bus.Out_addr}), 0);
    endtask

    initial begin
        int wr0;
        int d0;
        bus.Start     = 1'b0;
        bus.Abort     = 1'b0;
        bus.Mac_ready = 1'b1;
        bus.Cfg_n_in  = '0;
        bus.Cfg_n_out = '0;
        fork
            monitor();
        join_none

        #1;
        check_quiet("in_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("after_reset");

        // 3x2 run, no stalls: Done at cycle 13
        run(3, 2, -1, -2, -1, 1000, 0, -1, -1);
        // same run stalled at cycles 3-4: W_addr held at 1, Done at cycle 15
        run(3, 2, 3, 4, -1, 1000, 0, -1, 1);
        // illegal configurations
        run(3, 0, -1, -2, -1, 1000, 3, 1, -1);
        run(0, 2, -1, -2, -1, 1000, 3, 1, -1);
        // abort at cycle 8, idle from cycle 9, then a clean run from W_addr 0
        run(3, 2, -1, -2, 8, 8, 11, 9, -1);
        run(3, 2, -1, -2, -1, 1000, 0, -1, -1);

        // reset mid-MAC (cycle 3)
        run(3, 2, -1, -2, -1, 4, 3, -1, -1);
        #1;
        rst_n = 1'b0;
        #1;
        check_quiet("mid_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("post_mid_reset");
        run(2, 1, -1, -2, -1, 1000, 0, -1, -1);

        // largest legal configuration
        wr0 = wr_cnt;
        d0  = done_cnt;
        run(31, 31, -1, -2, -1, 100000, 0, -1, -1);
        check("max_wr_out_count", wr_cnt - wr0, 31);
        check("max_done_count", done_cnt - d0, 1);
        check("max_last_w_addr", last_w, 960);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
